// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchroniser, stability-counter debounce FSM, one-cycle press/release
// pulses and optional hold-to-repeat.
module button_debounce_pulse #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic PB_raw,
    output logic out_DebouncedPulse,
    output logic out_ReleasePulse,
    output logic out_DebouncedLevel
);

    localparam int unsigned StableW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RepeatMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned RepeatW   = $clog2(RepeatMax + 1);
    localparam bit          RepeatEn  = (REPEAT_DELAY != 0);

    localparam logic [StableW-1:0] StableTarget = StableW'(STABLE_CYCLES);
    localparam logic [RepeatW-1:0] DelayTarget  = RepeatW'(REPEAT_DELAY);
    localparam logic [RepeatW-1:0] PeriodTarget = RepeatW'(REPEAT_PERIOD);
    localparam logic [RepeatW-1:0] RepeatSat    = RepeatW'(RepeatMax);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StRelWait
    } state_e;

    state_e               stateQ, stateD;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                 sync;
    logic [StableW-1:0]   stableCntQ, stableCntD, stableInc;
    logic [RepeatW-1:0]   repeatCntQ, repeatCntD, repeatStep;
    logic                 repeatArmedQ, repeatArmedD;
    logic                 pressPulseQ, pressPulseD;
    logic                 releasePulseQ, releasePulseD;

    assign sync = syncQ[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ         <= '0;
            stateQ        <= StReleased;
            stableCntQ    <= '0;
            repeatCntQ    <= '0;
            repeatArmedQ  <= 1'b0;
            pressPulseQ   <= 1'b0;
            releasePulseQ <= 1'b0;
        end else begin
            syncQ         <= {syncQ[SYNC_STAGES-2:0], PB_raw};
            stateQ        <= stateD;
            stableCntQ    <= stableCntD;
            repeatCntQ    <= repeatCntD;
            repeatArmedQ  <= repeatArmedD;
            pressPulseQ   <= pressPulseD;
            releasePulseQ <= releasePulseD;
        end
    end

    assign stableInc  = (stableCntQ == StableTarget) ? stableCntQ : stableCntQ + 1'b1;
    assign repeatStep = (repeatCntQ == RepeatSat) ? repeatCntQ : repeatCntQ + 1'b1;

    always_comb begin
        stateD        = stateQ;
        stableCntD    = stableCntQ;
        repeatCntD    = repeatCntQ;
        repeatArmedD  = repeatArmedQ;
        pressPulseD   = 1'b0;
        releasePulseD = 1'b0;

        unique case (stateQ)
            StReleased: begin
                if (sync) begin
                    stateD     = StPressWait;
                    stableCntD = StableW'(1);
                end
            end
            StPressWait: begin
                if (!sync) begin
                    stateD     = StReleased;
                    stableCntD = '0;
                end else if (stableCntQ >= StableTarget) begin
                    stateD       = StPressed;
                    stableCntD   = '0;
                    pressPulseD  = 1'b1;
                    repeatCntD   = '0;
                    repeatArmedD = 1'b0;
                end else begin
                    stableCntD = stableInc;
                end
            end
            StPressed: begin
                if (!sync) begin
                    stateD     = StRelWait;
                    stableCntD = StableW'(1);
                end
            end
            StRelWait: begin
                // A bounce back high resumes PRESSED without a new press pulse
                if (sync) begin
                    stateD     = StPressed;
                    stableCntD = '0;
                end else if (stableCntQ >= StableTarget) begin
                    stateD        = StReleased;
                    stableCntD    = '0;
                    releasePulseD = 1'b1;
                    repeatCntD    = '0;
                    repeatArmedD  = 1'b0;
                end else begin
                    stableCntD = stableInc;
                end
            end
            default: stateD = StReleased;
        endcase

        // Repeat timing spans PRESSED and REL_WAIT; suppressed on the edge that releases
        if (RepeatEn && (stateQ == StPressed || stateQ == StRelWait) && stateD != StReleased) begin
            if ((!repeatArmedQ && repeatStep == DelayTarget) ||
                (repeatArmedQ && repeatStep == PeriodTarget)) begin
                pressPulseD  = 1'b1;
                repeatCntD   = '0;
                repeatArmedD = 1'b1;
            end else begin
                repeatCntD = repeatStep;
            end
        end
    end

    assign out_DebouncedPulse = pressPulseQ;
    assign out_ReleasePulse   = releasePulseQ;
    assign out_DebouncedLevel = (stateQ == StPressed) || (stateQ == StRelWait);

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench: a plain instance and an auto-repeat instance share one button input; expected
// pulse events are queued per instance and matched cycle by cycle.
module tb_button_debounce_pulse;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic PB_raw = 1'b0;
    logic pulseA, relA, levelA, pulseB, relB, levelB;

    int checks = 0;
    int failures = 0;
    int cyc = -1;

    typedef struct {
        int   cyc;
        logic press;
        logic rel;
    } ev_t;

    ev_t  qA[$];
    ev_t  qB[$];
    logic expLvlA = 1'b0;
    logic expLvlB = 1'b0;

    always #5 clk = ~clk;

    button_debounce_pulse #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (0),
        .REPEAT_PERIOD(8)
    ) dutA (
        .clk               (clk),
        .reset             (reset),
        .PB_raw            (PB_raw),
        .out_DebouncedPulse(pulseA),
        .out_ReleasePulse  (relA),
        .out_DebouncedLevel(levelA)
    );

    button_debounce_pulse #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dutB (
        .clk               (clk),
        .reset             (reset),
        .PB_raw            (PB_raw),
        .out_DebouncedPulse(pulseB),
        .out_ReleasePulse  (relB),
        .out_DebouncedLevel(levelB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushEv(input bit isB, input int c, input bit p, input bit r);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        if (isB) qB.push_back(e);
        else qA.push_back(e);
    endtask

    // Pop any event due this cycle and compare {pulse, release, level} of both instances
    task automatic sample();
        logic [1:0] eA, eB;
        eA = 2'b00;
        eB = 2'b00;
        if (qA.size() > 0 && qA[0].cyc == cyc) begin
            eA = {qA[0].press, qA[0].rel};
            void'(qA.pop_front());
        end
        if (qB.size() > 0 && qB[0].cyc == cyc) begin
            eB = {qB[0].press, qB[0].rel};
            void'(qB.pop_front());
        end
        if (reset) begin
            expLvlA = 1'b0;
            expLvlB = 1'b0;
        end
        if (eA[1]) expLvlA = 1'b1;
        if (eA[0]) expLvlA = 1'b0;
        if (eB[1]) expLvlB = 1'b1;
        if (eB[0]) expLvlB = 1'b0;
        chk($sformatf("plain cycle %0d {pulse,rel,level}", cyc),
            {29'd0, pulseA, relA, levelA}, {29'd0, eA, expLvlA});
        chk($sformatf("repeat cycle %0d {pulse,rel,level}", cyc),
            {29'd0, pulseB, relB, levelB}, {29'd0, eB, expLvlB});
    endtask

    task automatic step(input bit v);
        PB_raw = v;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sample();
    endtask

    task automatic runSeg(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic doReset();
        reset  = 1'b1;
        PB_raw = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset plain outputs", {29'd0, pulseA, relA, levelA}, 32'd0);
        chk("reset repeat outputs", {29'd0, pulseB, relB, levelB}, 32'd0);
        reset   = 1'b0;
        cyc     = -1;
        expLvlA = 1'b0;
        expLvlB = 1'b0;
        qA.delete();
        qB.delete();
    endtask

    task automatic endTest(input string name);
        chk({name, " plain events left"}, qA.size(), 32'd0);
        chk({name, " repeat events left"}, qB.size(), 32'd0);
    endtask

    initial begin
        // Clean press at edge 10
        doReset();
        pushEv(0, 16, 1, 0);
        pushEv(1, 16, 1, 0);
        runSeg(0, 10);
        runSeg(1, 11);
        endTest("clean press");

        // Bounce then held from edge 20
        doReset();
        pushEv(0, 26, 1, 0);
        pushEv(1, 26, 1, 0);
        runSeg(0, 15);
        step(1); step(0); step(1); step(1); step(0);
        runSeg(1, 11);
        endTest("bounce");

        // Release at edge 40 with a 2-cycle high glitch at 42-43; repeats continue through it
        doReset();
        pushEv(0, 6, 1, 0);
        pushEv(0, 50, 0, 1);
        pushEv(1, 6, 1, 0);
        pushEv(1, 26, 1, 0);
        pushEv(1, 34, 1, 0);
        pushEv(1, 42, 1, 0);
        pushEv(1, 50, 0, 1);
        runSeg(1, 40);
        runSeg(0, 2);
        runSeg(1, 2);
        runSeg(0, 12);
        endTest("release glitch");

        // Short 3-cycle pulse is filtered
        doReset();
        runSeg(0, 5);
        runSeg(1, 3);
        runSeg(0, 13);
        endTest("short pulse");

        // Long hold: repeat on 58 coincides with release and must be dropped
        doReset();
        pushEv(0, 6, 1, 0);
        pushEv(0, 58, 0, 1);
        pushEv(1, 6, 1, 0);
        pushEv(1, 26, 1, 0);
        pushEv(1, 34, 1, 0);
        pushEv(1, 42, 1, 0);
        pushEv(1, 50, 1, 0);
        pushEv(1, 58, 0, 1);
        runSeg(1, 52);
        runSeg(0, 18);
        endTest("auto repeat");

        // Reset at edges 20-21 while held: no release pulse, fresh press at 28
        doReset();
        pushEv(0, 6, 1, 0);
        pushEv(0, 28, 1, 0);
        pushEv(1, 6, 1, 0);
        pushEv(1, 28, 1, 0);
        runSeg(1, 20);
        reset = 1'b1;
        runSeg(1, 2);
        reset = 1'b0;
        runSeg(1, 19);
        endTest("mid reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
